// File: rtl/pe_ctrl_stride.sv
// PE-array controller: tracks accepted samples through a LAT-deep result pipeline,
// groups results into patches of stride_cycle vectors and drives PE / write-back strobes.
module pe_ctrl_stride #(
    parameter int LAT    = 4,
    parameter int CYC_W  = 4,
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             conv_en,
    input  logic [CYC_W-1:0] stride_cycle,
    input  logic             force_wb,
    input  logic             buff_full,
    output logic             out_accum,
    output logic             out_en,
    output logic [CH_W-1:0]  out_ch,
    output logic             wb_en,
    output logic             stall,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             adv;
    logic             accept;
    logic             force_acc;
    logic [LAT-2:0]   vld_p;
    logic             r_vld;

    logic [CYC_W-1:0] cnt, cnt_nxt;
    logic [CYC_W-1:0] n_q, n_nxt;
    logic [CYC_W-1:0] n_cur;
    logic [CH_W-1:0]  ch_nxt;
    logic             acc_nxt, oen_nxt, wb_nxt;
    logic             acc_p1, oen_p1, wb_p1;

    // A zero patch length behaves as one vector per patch.
    function automatic logic [CYC_W-1:0] sat_len(input logic [CYC_W-1:0] s);
        return (s == '0) ? CYC_W'(1) : s;
    endfunction

    assign adv       = ~buff_full;
    assign accept    = conv_en & adv;
    assign force_acc = force_wb & adv;
    assign r_vld     = vld_p[LAT-2];
    assign n_cur     = (cnt == CYC_W'(1)) ? sat_len(stride_cycle) : n_q;

    // Stage p0: sample-valid shift register, frozen while the buffer is full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p <= '0;
        end else if (adv) begin
            for (int i = LAT - 2; i > 0; i--) begin
                vld_p[i] <= vld_p[i-1];
            end
            vld_p[0] <= accept;
        end
    end

    always_comb begin
        acc_nxt = 1'b0;
        oen_nxt = 1'b0;
        wb_nxt  = 1'b0;
        cnt_nxt = cnt;
        n_nxt   = n_q;
        ch_nxt  = oen_p1 ? out_ch + CH_W'(1) : out_ch;
        if (force_acc) begin
            // The result arriving with the flush belongs to the discarded partial patch.
            cnt_nxt = CYC_W'(1);
            ch_nxt  = '0;
            wb_nxt  = 1'b1;
        end else if (r_vld) begin
            if (cnt == CYC_W'(1)) begin
                n_nxt = sat_len(stride_cycle);
            end
            if (cnt >= n_cur) begin
                oen_nxt = 1'b1;
                cnt_nxt = CYC_W'(1);
                wb_nxt  = (ch_nxt == CH_W'(NUM_CH - 1));
            end else begin
                acc_nxt = 1'b1;
                cnt_nxt = cnt + CYC_W'(1);
            end
        end
    end

    // Stage p1: registered strobes and patch bookkeeping; held across a stall so the
    // pending strobe re-issues once the buffer drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_p1 <= 1'b0;
            oen_p1 <= 1'b0;
            wb_p1  <= 1'b0;
            cnt    <= CYC_W'(1);
            n_q    <= CYC_W'(1);
            out_ch <= '0;
        end else if (adv) begin
            acc_p1 <= acc_nxt;
            oen_p1 <= oen_nxt;
            wb_p1  <= wb_nxt;
            cnt    <= cnt_nxt;
            n_q    <= n_nxt;
            out_ch <= ch_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (adv && !conv_en) state_nxt = DRAIN;
            DRAIN: begin
                if (accept) begin
                    state_nxt = RUN;
                end else if (adv && (vld_p == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign out_accum = acc_p1 & ~buff_full;
    assign out_en    = oen_p1 & ~buff_full;
    assign wb_en     = wb_p1 & ~buff_full;
    assign stall     = buff_full;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pe_ctrl_stride.sv
// Directed bench for pe_ctrl_stride: six scenarios, per-cycle expected strobes,
// channel and busy values written out by hand.
module tb_pe_ctrl_stride;

    localparam int LAT    = 4;
    localparam int CYC_W  = 4;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int NC     = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             conv_en;
    logic [CYC_W-1:0] stride_cycle;
    logic             force_wb;
    logic             buff_full;
    logic             out_accum;
    logic             out_en;
    logic [CH_W-1:0]  out_ch;
    logic             wb_en;
    logic             stall;
    logic             busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [NC-1:0] conv_m, bf_m, fw_m, acc_m, en_m, wb_m, busy_m;
    int            str_a, str_b, sw_c, rst_c;
    int            ch_e[NC];

    pe_ctrl_stride #(
        .LAT(LAT), .CYC_W(CYC_W), .NUM_CH(NUM_CH), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .conv_en(conv_en), .stride_cycle(stride_cycle),
        .force_wb(force_wb), .buff_full(buff_full), .out_accum(out_accum),
        .out_en(out_en), .out_ch(out_ch), .wb_en(wb_en), .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [NC-1:0] rg(input int lo, input int hi);
        logic [NC-1:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic setup(input int s);
        conv_m = '0; bf_m = '0; fw_m = '0; acc_m = '0; en_m = '0; wb_m = '0; busy_m = '0;
        str_a = 1; str_b = 1; sw_c = NC; rst_c = -10;
        ch_e = '{default: 0};
        case (s)
            1: begin
                str_a = 3; conv_m = rg(0, 5);
                acc_m = rg(4, 5) | rg(7, 8); en_m = rg(6, 6) | rg(9, 9);
                busy_m = rg(1, 9);
                ch_e = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2};
            end
            2: begin
                str_a = 1; conv_m = rg(0, 7);
                en_m = rg(4, 11); wb_m = rg(7, 7) | rg(11, 11);
                busy_m = rg(1, 11);
                ch_e = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 0, 0};
            end
            3: begin
                str_a = 2; conv_m = rg(0, 15); bf_m = rg(5, 7);
                acc_m = rg(4, 4) | rg(9, 9) | rg(11, 11) | rg(13, 13) | rg(15, 15);
                en_m = rg(8, 8) | rg(10, 10) | rg(12, 12) | rg(14, 14);
                wb_m = rg(14, 14); busy_m = rg(1, 15);
                ch_e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 0};
            end
            4: begin
                str_a = 4; conv_m = rg(0, 15); fw_m = rg(6, 6);
                acc_m = rg(4, 6) | rg(8, 10) | rg(12, 14);
                en_m = rg(11, 11) | rg(15, 15); wb_m = rg(7, 7); busy_m = rg(1, 15);
                ch_e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
            end
            5: begin
                str_a = 2; str_b = 3; sw_c = 5; conv_m = rg(0, 15);
                acc_m = rg(4, 4) | rg(6, 7) | rg(9, 10) | rg(12, 13) | rg(15, 15);
                en_m = rg(5, 5) | rg(8, 8) | rg(11, 11) | rg(14, 14);
                wb_m = rg(14, 14); busy_m = rg(1, 15);
                ch_e = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
            end
            default: begin
                str_a = 3; conv_m = rg(0, 4); rst_c = 5;
                acc_m = rg(4, 4); busy_m = rg(1, 4);
            end
        endcase
    endtask

    task automatic run_scn(input int s);
        setup(s);
        reset = 1'b0; conv_en = 1'b0; force_wb = 1'b0; buff_full = 1'b0;
        stride_cycle = CYC_W'(str_a);
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("s%0d rst accum", s), 32'(out_accum), 32'd0);
        check($sformatf("s%0d rst en", s), 32'(out_en), 32'd0);
        check($sformatf("s%0d rst wb", s), 32'(wb_en), 32'd0);
        check($sformatf("s%0d rst busy", s), 32'(busy), 32'd0);
        check($sformatf("s%0d rst ch", s), 32'(out_ch), 32'd0);
        check($sformatf("s%0d rst stall", s), 32'(stall), 32'd0);
        reset = 1'b1;
        for (int c = 0; c < NC; c++) begin
            @(posedge clk);
            #1;
            conv_en      = conv_m[c];
            buff_full    = bf_m[c];
            force_wb     = fw_m[c];
            stride_cycle = CYC_W'((c < sw_c) ? str_a : str_b);
            if (c == rst_c) reset = 1'b0;
            if (c == rst_c + 1) reset = 1'b1;
            #1;
            check($sformatf("s%0d c%0d accum", s, c), 32'(out_accum), 32'(acc_m[c]));
            check($sformatf("s%0d c%0d en", s, c), 32'(out_en), 32'(en_m[c]));
            check($sformatf("s%0d c%0d wb", s, c), 32'(wb_en), 32'(wb_m[c]));
            check($sformatf("s%0d c%0d busy", s, c), 32'(busy), 32'(busy_m[c]));
            check($sformatf("s%0d c%0d ch", s, c), 32'(out_ch), 32'(ch_e[c]));
            check($sformatf("s%0d c%0d stall", s, c), 32'(stall), 32'(bf_m[c]));
        end
        conv_en = 1'b0; force_wb = 1'b0; buff_full = 1'b0;
    endtask

    initial begin
        for (int s = 1; s <= 6; s++) run_scn(s);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
